cordic_prefold: RTL and testbench

Front-end stage that sits directly upstream of the CORDIC `pipeline` and drives its degree_in/x_in/y_in/flip_in/arctan_en_in/valid_in.
- Accepts requests over a valid/ready handshake with a wide signed angle.
- Rotation mode: reduces the angle modulo 360 with a multi-cycle FSM, then folds it into [-90,90] so the pipeline's convergence range holds.
- Vectoring (arctan) mode: reflects negative-x vectors into the right half-plane.
- Records the correction in flip_out for the downstream post-correction stage.

---
 rtl/cordic_prefold.sv | 147 ++++++++++++++
 tb/tb_cordic_prefold.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_prefold.sv
// Front-end for the CORDIC pipeline: reduces rotation angles mod 360, folds them into [-90,90], reflects vectoring inputs.
// Latency: accept edge E0, FOLD edge at E2+N (N = wraps), valid_out high the cycle after; issue interval >= 3 cycles.
// Backpressure: in_ready is high only in IDLE; no backpressure is taken from the downstream pipeline.
module cordic_prefold #(
  parameter int INPUT_WIDTH      = 16,
  parameter int INPUT_FRAC_WIDTH = 8,
  parameter int ANGLE_INT_WIDTH  = 9,
  parameter int FLIP_FLAG_WIDTH  = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [ANGLE_INT_WIDTH+INPUT_FRAC_WIDTH:0]      in_degree,
  input  logic [INPUT_WIDTH-1:0]                         in_x,
  input  logic [INPUT_WIDTH-1:0]                         in_y,
  input  logic                                           in_arctan_en,
  output logic [INPUT_WIDTH-1:0]                         degree_out,
  output logic [INPUT_WIDTH-1:0]                         x_out,
  output logic [INPUT_WIDTH-1:0]                         y_out,
  output logic [FLIP_FLAG_WIDTH-1:0]                     flip_out,
  output logic                                           arctan_en_out,
  output logic                                           valid_out,
  output logic                                           busy
);

  localparam int ANG_W = 1 + ANGLE_INT_WIDTH + INPUT_FRAC_WIDTH;

  localparam logic signed [ANG_W-1:0] DEG90  = ANG_W'(90  << INPUT_FRAC_WIDTH);
  localparam logic signed [ANG_W-1:0] DEG180 = ANG_W'(180 << INPUT_FRAC_WIDTH);
  localparam logic signed [ANG_W-1:0] DEG360 = ANG_W'(360 << INPUT_FRAC_WIDTH);

  localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_NONE = FLIP_FLAG_WIDTH'(0);
  localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_ROT  = FLIP_FLAG_WIDTH'(1);
  localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_VEC  = FLIP_FLAG_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, REDUCE, FOLD} state_t;

  state_t state, state_nxt;

  logic signed [ANG_W-1:0]       angle;
  logic signed [INPUT_WIDTH-1:0] x_q, y_q;
  logic                          arctan_q;

  logic                          accept;
  logic                          wrap_hi, wrap_lo;

  logic signed [ANG_W-1:0]       fold_ang;
  logic [INPUT_WIDTH-1:0]        fold_deg, fold_x, fold_y;
  logic [FLIP_FLAG_WIDTH-1:0]    fold_flip;

  // Negation that maps the most negative code to the most positive one instead of wrapping.
  function automatic logic [INPUT_WIDTH-1:0] neg_sat(input logic signed [INPUT_WIDTH-1:0] v);
    if (v == {1'b1, {(INPUT_WIDTH-1){1'b0}}})
      neg_sat = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    else
      neg_sat = -v;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign wrap_hi  = (angle >= DEG180);
  assign wrap_lo  = (angle < -DEG180);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: reduce one 360-degree step per cycle until the angle lies in [-180,180).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REDUCE;
      REDUCE:  if (!wrap_hi && !wrap_lo) state_nxt = FOLD;
      FOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and modulo-360 reduction of the working angle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      angle    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      arctan_q <= 1'b0;
    end else if (accept) begin
      angle    <= in_degree;
      x_q      <= in_x;
      y_q      <= in_y;
      arctan_q <= in_arctan_en;
    end else if (state == REDUCE) begin
      if (wrap_hi)      angle <= angle - DEG360;
      else if (wrap_lo) angle <= angle + DEG360;
    end
  end

  // Fold the reduced angle into [-90,90], or reflect a left-half-plane vector.
  always_comb begin
    fold_ang  = angle;
    fold_deg  = '0;
    fold_x    = x_q;
    fold_y    = y_q;
    fold_flip = FLIP_NONE;
    if (arctan_q) begin
      if (x_q < 0) begin
        fold_x    = neg_sat(x_q);
        fold_y    = neg_sat(y_q);
        fold_flip = FLIP_VEC;
      end
    end else begin
      if (angle > DEG90) begin
        fold_ang  = angle - DEG180;
        fold_flip = FLIP_ROT;
      end else if (angle < -DEG90) begin
        fold_ang  = angle + DEG180;
        fold_flip = FLIP_ROT;
      end
      fold_deg = fold_ang[INPUT_WIDTH-1:0];
    end
  end

  // Output registers: loaded on the FOLD exit edge and held until the next FOLD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      degree_out    <= '0;
      x_out         <= '0;
      y_out         <= '0;
      flip_out      <= '0;
      arctan_en_out <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= (state == FOLD);
      if (state == FOLD) begin
        degree_out    <= fold_deg;
        x_out         <= fold_x;
        y_out         <= fold_y;
        flip_out      <= fold_flip;
        arctan_en_out <= arctan_q;
      end
    end
  end

endmodule

// File: tb/tb_cordic_prefold.sv
// Directed bench for cordic_prefold: reset state, rotation fold/wrap cases, vectoring reflection,
// back-to-back issue with in_valid held high, and a reset abort in the middle of REDUCE.
// All expected values are hand-computed constants in the vector table.
module tb_cordic_prefold;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_degree;
  logic [15:0] in_x, in_y;
  logic        in_arctan_en;
  logic [15:0] degree_out, x_out, y_out;
  logic [1:0]  flip_out;
  logic        arctan_en_out, valid_out, busy;

  int n_chk  = 0;
  int n_fail = 0;

  cordic_prefold dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_degree(in_degree), .in_x(in_x), .in_y(in_y), .in_arctan_en(in_arctan_en),
    .degree_out(degree_out), .x_out(x_out), .y_out(y_out), .flip_out(flip_out),
    .arctan_en_out(arctan_en_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [17:0] deg;
    logic [15:0] x, y;
    logic        arc;
    logic [15:0] e_deg, e_x, e_y;
    logic [1:0]  e_flip;
    int          e_lat;
  } vec_t;

  vec_t vecs[12];

  // One request: present at a negedge, accept on the next posedge, then count cycles to valid_out.
  task automatic do_req(input int idx);
    vec_t v;
    int   lat;
    bit   seen;
    v = vecs[idx];
    @(negedge clk);
    in_degree    = v.deg;
    in_x         = v.x;
    in_y         = v.y;
    in_arctan_en = v.arc;
    in_valid     = 1'b1;
    chk($sformatf("v%0d_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = 16'hDEAD;
    lat  = 1;
    seen = 0;
    while (!seen && lat < 20) begin
      if (valid_out) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("v%0d_seen", idx), seen, 1);
    chk($sformatf("v%0d_lat", idx), lat, v.e_lat);
    chk($sformatf("v%0d_deg", idx), degree_out, v.e_deg);
    chk($sformatf("v%0d_x", idx), x_out, v.e_x);
    chk($sformatf("v%0d_y", idx), y_out, v.e_y);
    chk($sformatf("v%0d_flip", idx), flip_out, v.e_flip);
    chk($sformatf("v%0d_arc", idx), arctan_en_out, v.arc);
    chk($sformatf("v%0d_ready_at_valid", idx), in_ready, 1);
    @(negedge clk);
    chk($sformatf("v%0d_pulse_one", idx), valid_out, 0);
    chk($sformatf("v%0d_hold_deg", idx), degree_out, v.e_deg);
  endtask

  logic [17:0] b2b_deg[3];
  logic [15:0] b2b_exp[3];
  int          acc_cyc[3];

  initial begin
    //          deg       x        y        arc  e_deg     e_x      e_y      flip  lat
    vecs[0]  = '{18'h00C00, 16'h0100, 16'h0402, 1'b0, 16'h0C00, 16'h0100, 16'h0402, 2'd0, 3}; // 12
    vecs[1]  = '{18'h07800, 16'h0100, 16'h0200, 1'b0, 16'hC400, 16'h0100, 16'h0200, 2'd1, 3}; // 120 -> -60
    vecs[2]  = '{18'h39C00, 16'h0300, 16'h0400, 1'b0, 16'h5000, 16'h0300, 16'h0400, 2'd1, 3}; // -100 -> 80
    vecs[3]  = '{18'h05A00, 16'h0000, 16'h0100, 1'b0, 16'h5A00, 16'h0000, 16'h0100, 2'd0, 3}; // +90 kept
    vecs[4]  = '{18'h3A600, 16'h0000, 16'h0100, 1'b0, 16'hA600, 16'h0000, 16'h0100, 2'd0, 3}; // -90 kept
    vecs[5]  = '{18'h19000, 16'h0100, 16'h0100, 1'b0, 16'h2800, 16'h0100, 16'h0100, 2'd0, 4}; // 400 -> 40
    vecs[6]  = '{18'h20000, 16'h0100, 16'h0100, 1'b0, 16'h1C00, 16'h0100, 16'h0100, 2'd1, 4}; // -512 -> -152 -> 28
    vecs[7]  = '{18'h34C00, 16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h0100, 16'h0100, 2'd1, 3}; // -180 -> 0
    vecs[8]  = '{18'h0B400, 16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h0100, 16'h0100, 2'd1, 4}; // +180 -> -180 -> 0
    vecs[9]  = '{18'h00C00, 16'hFF00, 16'h0400, 1'b1, 16'h0000, 16'h0100, 16'hFC00, 2'd2, 3}; // reflect
    vecs[10] = '{18'h00000, 16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h7FFF, 16'h7FFF, 2'd2, 3}; // saturate
    vecs[11] = '{18'h00000, 16'h0000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 16'h8000, 2'd0, 3}; // x==0 not neg

    b2b_deg[0] = 18'h00A00; b2b_exp[0] = 16'h0A00;
    b2b_deg[1] = 18'h01400; b2b_exp[1] = 16'h1400;
    b2b_deg[2] = 18'h01E00; b2b_exp[2] = 16'h1E00;

    reset = 1'b0; in_valid = 1'b0; in_degree = '0; in_x = '0; in_y = '0; in_arctan_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_deg", degree_out, 0);
    chk("rst_xy", {x_out, y_out}, 0);
    chk("rst_flip_arc", {flip_out, arctan_en_out}, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) do_req(i);

    // Back-to-back: in_valid stays high while three requests are issued.
    begin
      int c, accn, outn;
      c = 0; accn = 0; outn = 0;
      @(negedge clk);
      while (outn < 3 && c < 40) begin
        if (valid_out) begin
          chk($sformatf("b2b%0d_deg", outn), degree_out, b2b_exp[outn]);
          chk($sformatf("b2b%0d_flip", outn), flip_out, 0);
          outn++;
        end
        chk("b2b_ready_vs_busy", in_ready, !busy);
        if (accn < 3) begin
          in_degree = b2b_deg[accn]; in_x = 16'h0100; in_y = 16'h0000;
          in_arctan_en = 1'b0; in_valid = 1'b1;
          if (in_ready) begin
            acc_cyc[accn] = c;
            accn++;
          end
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        c++;
      end
      in_valid = 1'b0;
      chk("b2b_count", outn, 3);
      chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 3);
      chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 3);
    end

    // Abort: reset asserted while the 400-degree request is still reducing.
    begin
      bit pulsed;
      @(negedge clk);
      in_degree = 18'h19000; in_x = 16'h1234; in_y = 16'h5678; in_arctan_en = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_busy_before", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_deg", degree_out, 0);
      chk("abort_xy", {x_out, y_out}, 0);
      chk("abort_flip_arc", {flip_out, arctan_en_out}, 0);
      pulsed = 0;
      for (int k = 0; k < 8; k++) begin
        if (valid_out) pulsed = 1;
        @(negedge clk);
      end
      chk("abort_no_valid", pulsed, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
